fact_initiator: RTL and testbench
=================================

# fact_initiator

Memory-mapped bus initiator for the factorial accelerator register interface. It takes a one-cycle start request with a 4-bit operand and runs the full register protocol: write n, pulse go, poll status, read result. The 32-bit result comes back with done/err/timeout flags. It sits beside the MIPS core as a second driver of the fact accelerator's A/WE/WD/RD port (through the system's bus arbitration), so hardware can compute factorials without CPU polling.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: maximum POLL cycles before the operation aborts with timeout; legal range 1..65535.
- CNT_W, 16: width of the poll counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears the block immediately).
- start  in  1  request pulse; accepted only when busy=0.
- n_in  in  4  operand; sampled on the accepted start.
- busy  out  1  high from the cycle after an accepted start until the cycle after done.
- done  out  1  one-cycle completion pulse.
- result  out  32  factorial value; held until the next accepted start.
- err  out  1  accelerator flagged overflow; valid with done, held.
- timeout  out  1  poll budget exhausted; valid with done, held.
- bus_a  out  2  register address (word index).
- bus_we  out  1  write enable.
- bus_wd  out  4  write data.
- bus_rd  in  32  combinational read data from the accelerator.

## Operation
- Register map: 0 = n[3:0]; 1 = go (bit0); 2 = status {bit1 err, bit0 done}; 3 = result[31:0].
- FSM states: IDLE, WR_N, WR_GO, CLR_GO, POLL, RD_RES, RESP.
- IDLE: bus_we=0, bus_a=0. On start, latch n_in and clear result, err and timeout, then go to WR_N.
- WR_N: bus_we=1, bus_a=0, bus_wd=n. Next state is WR_GO.
- WR_GO: bus_we=1, bus_a=1, bus_wd=4'b0001. Next state is CLR_GO.
- CLR_GO: bus_we=1, bus_a=1, bus_wd=0. Next state is POLL; poll counter is set to 0.
- POLL: bus_we=0, bus_a=2, bus_rd sampled each cycle.
  - If bus_rd[0]=1: latch err=bus_rd[1] and go to RD_RES.
  - Else if counter = TIMEOUT_CYCLES-1: set timeout=1, set result=0 and go to RESP.
  - Else increment the counter.
- RD_RES: bus_we=0, bus_a=3. Latch result=bus_rd (also when err=1). Next state is RESP.
- RESP: done=1 for exactly this cycle. Next state is IDLE.
- start while busy=1 is ignored, not queued. start in the RESP cycle is also ignored.
- bus_wd=0 in every state that does not write.

## Timing
- Reset values: state=IDLE; busy, done, err, timeout, bus_we, bus_a, bus_wd, result all 0. Reset applies asynchronously and is released synchronously to clk by the system.
- Reset mid-operation: bus_we drops combinationally with reset, and no done pulse is issued. The accelerator itself is reset by the same system reset.
- All outputs are registered or decoded from registered state; there is no combinational path from start or bus_rd to any output.
- Cycle sequence for start high at edge k:
  - WR_N during cycle k+1, WR_GO k+2, CLR_GO k+3, first POLL k+4.
  - If done is first seen in POLL at cycle p: RD_RES is at p+1 and done pulses at p+2.
  - Minimum latency from start to done is 6 cycles.
- Timeout: with no done, the last POLL cycle is k+3+TIMEOUT_CYCLES, and done+timeout appear in the next cycle.

## Structure
- Shared package fact_bus_pkg holds:
  - register index constants FACT_A_N=0, FACT_A_GO=1, FACT_A_STAT=2, FACT_A_RES=3;
  - status bit positions STAT_DONE=0, STAT_ERR=1;
  - the FSM state enumeration.
- No sub-module is needed; the single FSM plus poll counter is one module.
- For simulation, the bench uses a separate behavioural responder, fact_resp_model. It is not synthesised.

## Test plan
- n_in=5, responder sets done 10 cycles after go -> exact WR_N/WR_GO/CLR_GO bus sequence, done at POLL+12, result=120, err=0, timeout=0.
- n_in=0, responder done immediately -> result=1, done 6 cycles after start.
- n_in=13, responder sets done with err=1 and RD=0 -> err=1, result=0, timeout=0, one done pulse.
- TIMEOUT_CYCLES=16, responder never sets done -> exactly 16 POLL cycles, then done=1, timeout=1, result=0, busy low the next cycle.
- start pulsed in WR_GO and again in POLL with n_in=7 -> both ignored; the original n_in=4 completes with result=24 and a single done pulse.
- reset driven low during POLL -> all outputs 0 immediately, no done; a new start with n_in=3 after release gives result=6.

Source files
------------

// File: rtl/fact_bus_pkg.sv
// Shared definitions for the factorial accelerator register bus:
// register indices, status bit positions and the initiator FSM states.
package fact_bus_pkg;

  localparam logic [1:0] FACT_A_N    = 2'd0;
  localparam logic [1:0] FACT_A_GO   = 2'd1;
  localparam logic [1:0] FACT_A_STAT = 2'd2;
  localparam logic [1:0] FACT_A_RES  = 2'd3;

  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_N   = 3'd1,
    WR_GO  = 3'd2,
    CLR_GO = 3'd3,
    POLL   = 3'd4,
    RD_RES = 3'd5,
    RESP   = 3'd6
  } fact_state_e;

endpackage

// File: rtl/fact_initiator.sv
// Bus initiator that runs one factorial job on the accelerator registers:
// write n, pulse go, poll status with a cycle budget, read the result.
module fact_initiator
  import fact_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  n_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  output logic        timeout,
  output logic [1:0]  bus_a,
  output logic        bus_we,
  output logic [3:0]  bus_wd,
  input  logic [31:0] bus_rd
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fact_state_e       r_state;
  logic [3:0]        r_n;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_result;
  logic              r_err;
  logic              r_timeout;

  fact_state_e       w_state_nxt;
  logic [3:0]        w_n_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [31:0]       w_result_nxt;
  logic              w_err_nxt;
  logic              w_timeout_nxt;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_n       <= 4'd0;
      r_cnt     <= '0;
      r_result  <= 32'd0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_n       <= w_n_nxt;
      r_cnt     <= w_cnt_nxt;
      r_result  <= w_result_nxt;
      r_err     <= w_err_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next-state and datapath update; start outside IDLE is simply dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_n_nxt       = r_n;
    w_cnt_nxt     = r_cnt;
    w_result_nxt  = r_result;
    w_err_nxt     = r_err;
    w_timeout_nxt = r_timeout;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_n_nxt       = n_in;
          w_result_nxt  = 32'd0;
          w_err_nxt     = 1'b0;
          w_timeout_nxt = 1'b0;
          w_state_nxt   = WR_N;
        end else begin
          w_state_nxt   = IDLE;
        end
      end
      WR_N:   w_state_nxt = WR_GO;
      WR_GO:  w_state_nxt = CLR_GO;
      CLR_GO: begin
        w_cnt_nxt   = '0;
        w_state_nxt = POLL;
      end
      POLL: begin
        // A done seen on the final budget cycle still wins over timeout.
        if (bus_rd[STAT_DONE]) begin
          w_err_nxt   = bus_rd[STAT_ERR];
          w_state_nxt = RD_RES;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_result_nxt  = 32'd0;
          w_state_nxt   = RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RD_RES: begin
        w_result_nxt = bus_rd;
        w_state_nxt  = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus and handshake outputs decoded purely from registered state.
  always_comb begin
    busy   = (r_state != IDLE);
    done   = (r_state == RESP);
    bus_we = 1'b0;
    bus_a  = FACT_A_N;
    bus_wd = 4'd0;
    case (r_state)
      WR_N: begin
        bus_we = 1'b1;
        bus_a  = FACT_A_N;
        bus_wd = r_n;
      end
      WR_GO: begin
        bus_we = 1'b1;
        bus_a  = FACT_A_GO;
        bus_wd = 4'b0001;
      end
      CLR_GO: begin
        bus_we = 1'b1;
        bus_a  = FACT_A_GO;
        bus_wd = 4'd0;
      end
      POLL:    bus_a = FACT_A_STAT;
      RD_RES:  bus_a = FACT_A_RES;
      default: begin
        bus_we = 1'b0;
        bus_a  = FACT_A_N;
        bus_wd = 4'd0;
      end
    endcase
  end

  assign result  = r_result;
  assign err     = r_err;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_fact_initiator.sv
// Self-checking bench for fact_initiator with a behavioural accelerator
// responder whose done flag appears a configurable number of POLL cycles in.
module tb_fact_initiator;

  localparam int T     = 16;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  n_in = 4'd0;
  logic        busy, done, err, timeout, bus_we;
  logic [31:0] result, bus_rd;
  logic [1:0]  bus_a;
  logic [3:0]  bus_wd;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cfg_delay = NEVER;

  logic [3:0]      acc_n;
  logic            acc_started;
  int              acc_go_cyc;
  logic            done_vis;
  longint unsigned acc_f;

  fact_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .n_in(n_in),
    .busy(busy), .done(done), .result(result), .err(err), .timeout(timeout),
    .bus_a(bus_a), .bus_we(bus_we), .bus_wd(bus_wd), .bus_rd(bus_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint unsigned ref_fact(input int n);
    longint unsigned f = 1;
    for (int i = 2; i <= n; i++) f = f * longint'(i);
    return f;
  endfunction

  // Responder: latches n, notes when go is written, flags done cfg_delay POLL cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_n       <= 4'd0;
      acc_started <= 1'b0;
      acc_go_cyc  <= 0;
    end else begin
      if (bus_we && bus_a == 2'd0) begin
        acc_n       <= bus_wd;
        acc_started <= 1'b0;
      end
      if (bus_we && bus_a == 2'd1 && bus_wd[0]) begin
        acc_started <= 1'b1;
        acc_go_cyc  <= cyc;
      end
    end
  end

  assign done_vis = acc_started && (cyc >= acc_go_cyc + 2 + cfg_delay);

  always_comb begin
    acc_f = ref_fact(int'(acc_n));
    case (bus_a)
      2'd0:    bus_rd = {28'd0, acc_n};
      2'd2:    bus_rd = {30'd0, done_vis && (acc_f > 64'hFFFF_FFFF), done_vis};
      2'd3:    bus_rd = (acc_f > 64'hFFFF_FFFF) ? 32'd0 : acc_f[31:0];
      default: bus_rd = 32'd0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One job; rel counts cycles after the start edge (rel=1 is the n write).
  task automatic run_txn(input logic [3:0] n, input int d, input int inj1, input int inj2,
                         input logic [31:0] exp_res, input logic exp_err, input logic exp_to,
                         input int exp_lat, input int exp_polls);
    int done_rel = -1;
    int ndone = 0;
    int polls = 0;
    logic [31:0] held;
    cfg_delay = d;
    @(negedge clk);
    start = 1'b1;
    n_in  = n;
    for (int rel = 1; rel <= 60; rel++) begin
      @(negedge clk);
      case (rel)
        1: begin
          chk("wr_n_bus", {bus_we, bus_a, bus_wd}, {1'b1, 2'd0, n});
          chk("start_clears", {result, err, timeout}, 34'd0);
          chk("busy_after_start", busy, 1'b1);
        end
        2:       chk("wr_go_bus", {bus_we, bus_a, bus_wd}, {1'b1, 2'd1, 4'd1});
        3:       chk("clr_go_bus", {bus_we, bus_a, bus_wd}, {1'b1, 2'd1, 4'd0});
        4:       chk("poll_bus", {bus_we, bus_a, bus_wd}, {1'b0, 2'd2, 4'd0});
        default: ;
      endcase
      if (bus_a == 2'd2 && !bus_we) polls++;
      if (done) begin
        ndone++;
        done_rel = rel;
        chk("result", result, exp_res);
        chk("err", err, exp_err);
        chk("timeout", timeout, exp_to);
        chk("busy_in_done", busy, 1'b1);
      end
      if (done_rel >= 0 && rel == done_rel + 1) begin
        chk("busy_after_done", {busy, done}, 2'b00);
        break;
      end
      start = (rel == inj1 || rel == inj2);
      n_in  = start ? 4'd7 : 4'($urandom);
    end
    start = 1'b0;
    chk("latency", done_rel, exp_lat);
    chk("done_pulses", ndone, 1);
    chk("poll_cycles", polls, exp_polls);
    held = result;
    repeat (2) @(negedge clk);
    chk("result_held", {result, busy}, {held, 1'b0});
  endtask

  typedef struct {
    logic [3:0]  n;
    int          d;
    logic [31:0] res;
    logic        e;
    logic        to;
    int          lat;
    int          polls;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{n: 4'd5,  d: 10,    res: 32'd120,       e: 1'b0, to: 1'b0, lat: 16, polls: 11};
    tbl[1] = '{n: 4'd0,  d: 0,     res: 32'd1,         e: 1'b0, to: 1'b0, lat: 6,  polls: 1};
    tbl[2] = '{n: 4'd13, d: 3,     res: 32'd0,         e: 1'b1, to: 1'b0, lat: 9,  polls: 4};
    tbl[3] = '{n: 4'd1,  d: NEVER, res: 32'd0,         e: 1'b0, to: 1'b1, lat: 20, polls: 16};
    tbl[4] = '{n: 4'd12, d: 15,    res: 32'd479001600, e: 1'b0, to: 1'b0, lat: 21, polls: 16};
    tbl[5] = '{n: 4'd15, d: 2,     res: 32'd0,         e: 1'b1, to: 1'b0, lat: 8,  polls: 3};
    tbl[6] = '{n: 4'd7,  d: 16,    res: 32'd0,         e: 1'b0, to: 1'b1, lat: 20, polls: 16};

    #1;
    chk("reset_outputs", {busy, done, err, timeout, bus_we, bus_a, bus_wd}, 64'd0);
    chk("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].n, tbl[i].d, -1, -1, tbl[i].res, tbl[i].e, tbl[i].to, tbl[i].lat, tbl[i].polls);

    // starts during WR_GO and POLL must be ignored
    run_txn(4'd4, 8, 2, 5, 32'd24, 1'b0, 1'b0, 14, 9);

    // reset in the middle of polling
    cfg_delay = NEVER;
    @(negedge clk);
    start = 1'b1;
    n_in  = 4'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_poll", {bus_we, bus_a}, {1'b0, 2'd2});
    reset = 1'b0;
    #1;
    chk("midreset_outputs", {busy, done, err, timeout, bus_we, bus_a, bus_wd}, 64'd0);
    chk("midreset_result", result, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_in_reset", {done, busy}, 2'b00);
    end
    reset = 1'b1;
    run_txn(4'd3, 2, -1, -1, 32'd6, 1'b0, 1'b0, 8, 3);

    // randomized jobs against the reference arithmetic
    for (int i = 0; i < 12; i++) begin
      logic [3:0]      rn;
      int              rd, ri;
      longint unsigned f;
      logic            ovf, to;
      rn  = 4'($urandom_range(0, 15));
      rd  = int'($urandom_range(0, 20));
      ri  = int'($urandom_range(1, 6));
      f   = ref_fact(int'(rn));
      to  = (rd >= T);
      ovf = (f > 64'hFFFF_FFFF);
      run_txn(rn, rd, ri, -1,
              (to || ovf) ? 32'd0 : f[31:0],
              !to && ovf, to,
              to ? T + 4 : rd + 6,
              to ? T : rd + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
